uart_rx_framed: RTL and testbench

Parametrised UART receiver: oversampled start-bit detection, configurable frame format, and a valid/ready output handshake with per-frame error flags. It sits between the board's serial input pin and the byte-consuming logic (command parser or FIFO). It replaces the fixed 8N1 receiver in new designs.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_rx_framed.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_framed.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver FSM states, tick divider and parameter legality.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } uart_state_e;

  // Clocks per oversample tick, truncated toward zero.
  function automatic int unsigned uart_div(input int unsigned base_freq,
                                           input int unsigned baudrate,
                                           input int unsigned oversample);
    return base_freq / (baudrate * oversample);
  endfunction

  function automatic bit uart_cfg_ok(input int unsigned data_bits,
                                     input int unsigned oversample,
                                     input int unsigned stop_bits,
                                     input int unsigned parity_odd,
                                     input int unsigned div);
    return (data_bits >= 5) && (data_bits <= 9) &&
           (oversample >= 8) && ((oversample % 2) == 0) &&
           ((stop_bits == 1) || (stop_bits == 2)) &&
           (parity_odd <= 1) && (div >= 1);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle tick_o every DIV clocks.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned DIV = 27
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] Last = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == Last);
    cnt_d  = tick_o ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_framed.sv
// Oversampling UART receiver with valid/ready output and per-frame error flags.
// Define UART_RX_PARITY_EN to expect a parity bit; otherwise parity_err is constant 0.
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int unsigned BASE_FREQ  = 50_000_000,
  parameter int unsigned BAUDRATE   = 115_200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned Div = uart_div(BASE_FREQ, BAUDRATE, OVERSAMPLE);
  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam logic [CntW-1:0] HalfLast = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(OVERSAMPLE - 1);
  localparam logic [3:0] DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0] StopLast = 4'(STOP_BITS - 1);

  if (!uart_cfg_ok(DATA_BITS, OVERSAMPLE, STOP_BITS, PARITY_ODD, Div)) begin : g_cfg_check
    $error("uart_rx_framed: illegal parameter combination");
  end

  logic                 tick;
  logic [1:0]           sync_q;
  logic                 line;
  uart_state_e          state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_q, ferr_d;
  logic                 sample, done, load;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  uart_baud_tick #(
    .DIV (Div)
  ) u_baud_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], serial_in};
    end
  end
  assign line = sync_q[1];

  // Mid-bit point for every bit after the start bit.
  assign sample = tick && (cnt_q == BitLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? cnt_q + CntW'(1) : cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ferr_d  = ferr_q;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        bit_d  = '0;
        ferr_d = 1'b0;
        if (!line) state_d = StStart;
      end
      StStart: begin
        if (tick && (cnt_q == HalfLast)) begin
          cnt_d   = '0;
          state_d = line ? StIdle : StData;
        end
      end
      StData: begin
        if (sample) begin
          cnt_d   = '0;
          shift_d = {line, shift_q[DATA_BITS-1:1]};
          if (bit_q == DataLast) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (sample) begin
          cnt_d   = '0;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (sample) begin
          cnt_d = '0;
          if (!line) ferr_d = 1'b1;
          if (bit_q == StopLast) begin
            bit_d   = '0;
            done    = 1'b1;
            state_d = line ? StIdle : StBreak;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (line) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A completing frame is taken if the slot is empty or being emptied this cycle.
  assign load = done && (!rx_valid_q || rx_ready);

  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = 1'b0;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (load) begin
      rx_data_d   = shift_q;
      frame_err_d = ferr_d;
      rx_valid_d  = 1'b1;
    end else if (done) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      ferr_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      ferr_q      <= ferr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d, parity_err_q, parity_err_d;

  always_comb begin
    perr_d       = perr_q;
    parity_err_d = parity_err_q;
    if (state_q == StIdle) begin
      perr_d = 1'b0;
    end else if ((state_q == StParity) && sample) begin
      perr_d = line ^ (^shift_q) ^ (PARITY_ODD != 0);
    end
    if (load) parity_err_d = perr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr_q       <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      perr_q       <= perr_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_framed.sv
// Self-checking bench for uart_rx_framed at default parameters (DIV=27, 432 clk per bit).
module tb_uart_rx_framed;

  localparam int unsigned OS     = 16;
  localparam int unsigned DIV    = 50_000_000 / (115_200 * OS);
  localparam int unsigned BIT    = DIV * OS;
  localparam bit          PAR_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, overrun, busy;

  uart_rx_framed #(
    .BASE_FREQ  (50_000_000),
    .BAUDRATE   (115_200),
    .DATA_BITS  (8),
    .OVERSAMPLE (OS),
    .STOP_BITS  (1),
    .PARITY_ODD (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } word_t;

  typedef struct {
    logic [7:0] data;
    int         stop_low;
    logic [7:0] exp_data;
    bit         exp_ferr;
    bit         exp_break;
  } vec_t;

  int    n_checks = 0;
  int    n_fail = 0;
  word_t got_q[$];
  int    run_len = 0, last_run = 0, ov_cycles = 0, hold_viol = 0, valid_rises = 0;
  logic  busy_at_rise = 1'b0, prev_valid = 1'b0, prev_hs = 1'b0;
  word_t prev_word = '0;

  // Observes handshakes, overrun pulses, valid run length and output stability.
  always @(negedge clk) begin
    word_t cur;
    cur = '{data: rx_data, ferr: frame_err, perr: parity_err};
    if (rx_valid && rx_ready) got_q.push_back(cur);
    if (overrun) ov_cycles++;
    if (rx_valid && !prev_valid) begin
      valid_rises++;
      busy_at_rise = busy;
    end
    if (rx_valid && prev_valid && !prev_hs && (cur != prev_word)) hold_viol++;
    if (rx_valid) begin
      run_len++;
    end else if (prev_valid) begin
      last_run = run_len;
      run_len  = 0;
    end
    prev_valid = rx_valid;
    prev_hs    = rx_valid && rx_ready;
    prev_word  = cur;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic good_pbit(input logic [7:0] d);
    return 1'(($countones(d) + int'(PAR_ODD)) % 2);
  endfunction

  // Reference: word as the line carried it, errors derived from the framing rules.
  function automatic word_t model(input logic [7:0] d, input logic pbit, input bit bad_stop);
    word_t w;
    w.data = d;
    w.ferr = bad_stop;
    w.perr = PAR_EN && ((($countones(d) + int'(pbit)) % 2) != int'(PAR_ODD));
    return w;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic pbit, input int stop_low);
    @(negedge clk);
    serial_in = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      repeat (BIT) @(negedge clk);
    end
    if (PAR_EN) begin
      serial_in = pbit;
      repeat (BIT) @(negedge clk);
    end
    if (stop_low > 0) begin
      serial_in = 1'b0;
      repeat (stop_low) @(negedge clk);
    end
    serial_in = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic wait_word(input string name, output word_t w, output bit ok);
    int n = 0;
    while ((got_q.size() == 0) && (n < int'(2 * BIT))) begin
      @(negedge clk);
      n++;
    end
    if (got_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no handshake within %0d clk, expected one word", name, 2 * BIT);
      ok = 1'b0;
      w  = '0;
    end else begin
      ok = 1'b1;
      w  = got_q.pop_front();
    end
  endtask

  task automatic check_word(input string name, input word_t g, input word_t e);
    check($sformatf("%s.data", name), 32'(g.data), 32'(e.data));
    check($sformatf("%s.frame_err", name), 32'(g.ferr), 32'(e.ferr));
    check($sformatf("%s.parity_err", name), 32'(g.perr), 32'(e.perr));
  endtask

  initial begin
    vec_t  vecs[5];
    word_t w;
    bit    ok;
    int    n_before, n;
    logic [7:0] d;
    logic  pb;

    vecs[0] = '{data: 8'hA5, stop_low: 0,        exp_data: 8'hA5, exp_ferr: 0, exp_break: 0};
    vecs[1] = '{data: 8'h3C, stop_low: int'(BIT), exp_data: 8'h3C, exp_ferr: 1, exp_break: 1};
    vecs[2] = '{data: 8'h55, stop_low: 0,        exp_data: 8'h55, exp_ferr: 0, exp_break: 0};
    vecs[3] = '{data: 8'h00, stop_low: 0,        exp_data: 8'h00, exp_ferr: 0, exp_break: 0};
    vecs[4] = '{data: 8'h81, stop_low: 0,        exp_data: 8'h81, exp_ferr: 0, exp_break: 0};

    repeat (3) @(negedge clk);
    check("reset.rx_valid", 32'(rx_valid), 0);
    check("reset.rx_data", 32'(rx_data), 0);
    check("reset.frame_err", 32'(frame_err), 0);
    check("reset.parity_err", 32'(parity_err), 0);
    check("reset.overrun", 32'(overrun), 0);
    check("reset.busy", 32'(busy), 0);
    rst = 1'b0;
    repeat (BIT) @(negedge clk);

    // Table: clean frames, bad stop through BREAK, and the frame after it.
    for (int i = 0; i < 5; i++) begin
      got_q.delete();
      send_frame(vecs[i].data, good_pbit(vecs[i].data), vecs[i].stop_low);
      wait_word($sformatf("vec%0d", i), w, ok);
      if (ok) begin
        check_word($sformatf("vec%0d", i), w,
                   '{data: vecs[i].exp_data, ferr: vecs[i].exp_ferr, perr: 1'b0});
        check($sformatf("vec%0d.busy_at_valid", i), 32'(busy_at_rise), 32'(vecs[i].exp_break));
      end
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d.valid_len", i), 32'(last_run), 1);
    end

    // Short low pulse is a false start.
    got_q.delete();
    n_before = valid_rises;
    @(negedge clk);
    serial_in = 1'b0;
    repeat (50) @(negedge clk);
    check("glitch.busy_high", 32'(busy), 1);
    repeat (50) @(negedge clk);
    serial_in = 1'b1;
    n = 0;
    while (busy && (n < int'(8 * DIV))) begin
      @(negedge clk);
      n++;
    end
    check("glitch.busy_dropped", 32'(busy), 0);
    repeat (BIT) @(negedge clk);
    check("glitch.no_valid", 32'(valid_rises - n_before), 0);

    // Overrun: second word dropped, first held, single pulse.
    got_q.delete();
    rx_ready  = 1'b0;
    ov_cycles = 0;
    send_frame(8'h11, good_pbit(8'h11), 0);
    send_frame(8'h22, good_pbit(8'h22), 0);
    check("overrun.rx_valid", 32'(rx_valid), 1);
    check("overrun.rx_data", 32'(rx_data), 32'h11);
    check("overrun.pulses", 32'(ov_cycles), 1);
    @(negedge clk);
    #2 rx_ready = 1'b1;
    @(negedge clk);
    check("overrun.valid_dropped", 32'(rx_valid), 0);

    // Reset in the middle of data bit 4 of 0xFF.
    got_q.delete();
    n_before = valid_rises;
    @(negedge clk);
    serial_in = 1'b0;
    repeat (BIT) @(negedge clk);
    serial_in = 1'b1;
    repeat (4 * BIT + BIT / 2) @(negedge clk);
    check("rstmid.busy_before", 32'(busy), 1);
    #1 rst = 1'b1;
    #1;
    check("rstmid.rx_valid", 32'(rx_valid), 0);
    check("rstmid.rx_data", 32'(rx_data), 0);
    check("rstmid.busy", 32'(busy), 0);
    check("rstmid.frame_err", 32'(frame_err), 0);
    check("rstmid.overrun", 32'(overrun), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5 * BIT) @(negedge clk);
    check("rstmid.no_valid", 32'(valid_rises - n_before), 0);
    send_frame(8'h5A, good_pbit(8'h5A), 0);
    wait_word("rstmid.after", w, ok);
    if (ok) check_word("rstmid.after", w, model(8'h5A, good_pbit(8'h5A), 1'b0));

    // Randomised frames against the reference model.
    for (int i = 0; i < 4; i++) begin
      got_q.delete();
      d  = 8'($urandom);
      pb = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 200)) @(negedge clk);
      send_frame(d, pb, 0);
      wait_word($sformatf("rand%0d", i), w, ok);
      if (ok) check_word($sformatf("rand%0d", i), w, model(d, pb, 1'b0));
    end

`ifdef UART_RX_PARITY_EN
    got_q.delete();
    send_frame(8'h07, 1'b0, 0);
    wait_word("parity.bad", w, ok);
    if (ok) check("parity.bad.parity_err", 32'(w.perr), 1);
    send_frame(8'h07, 1'b1, 0);
    wait_word("parity.good", w, ok);
    if (ok) check("parity.good.parity_err", 32'(w.perr), 0);
`endif

    check("hold_stable", 32'(hold_viol), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(99_000 * 10);
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
